// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared race FSM states, speed width and default tuning constants
//
// Contents:
//   race_state_t      : race FSM encoding (IDLE=0, RACE=1, CRASH=2, FINISH=3)
//   SPEED_W           : width of the player speed bus
//   DEF_*             : default tuning values for speed_controller parameters

package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RACE   = 2'd1,
        CRASH  = 2'd2,
        FINISH = 2'd3
    } race_state_t;

    localparam int SPEED_W = 10;

    localparam int DEF_MAX_SPEED    = 512;
    localparam int DEF_ACCEL        = 8;
    localparam int DEF_BRAKE        = 24;
    localparam int DEF_DRAG         = 2;
    localparam int DEF_CRASH_FRAMES = 60;

endpackage

// File: rtl/speed_controller.sv
// rtl/speed_controller.sv - per-frame player speed and race state machine
//
// Ports:
//   clk            : system clock
//   resetN         : asynchronous active-low reset
//   startOfFrame   : one-cycle pulse per video frame; all speed steps happen here
//   start_race     : level, starts the race from IDLE on a frame pulse
//   gas, brake     : pedal levels, sampled on frame pulses in RACE
//   collision      : pulse from object collision logic, honoured only in RACE
//   distance_drove : signed distance accumulated by the distance tracker
//   track_length   : signed race length
//   player_speed   : registered current speed
//   race_state     : registered FSM state
//   crash_active   : registered, high while in CRASH
//   race_done      : registered, high while in FINISH

module speed_controller
    import game_pkg::*;
#(
    parameter int MAX_SPEED    = DEF_MAX_SPEED,
    parameter int ACCEL        = DEF_ACCEL,
    parameter int BRAKE        = DEF_BRAKE,
    parameter int DRAG         = DEF_DRAG,
    parameter int CRASH_FRAMES = DEF_CRASH_FRAMES
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_race,
    input  logic               gas,
    input  logic               brake,
    input  logic               collision,
    input  logic [31:0]        distance_drove,
    input  logic [31:0]        track_length,
    output logic [SPEED_W-1:0] player_speed,
    output logic [1:0]         race_state,
    output logic               crash_active,
    output logic               race_done
);

    localparam int CNT_W = (CRASH_FRAMES < 2) ? 1 : $clog2(CRASH_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CRASH_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Speed math is done one bit wider than the speed bus so that an
    // addition past the ceiling is caught before it can wrap.
    localparam logic [SPEED_W:0] MAX_W   = (SPEED_W + 1)'(MAX_SPEED);
    localparam logic [SPEED_W:0] ACCEL_W = (SPEED_W + 1)'(ACCEL);
    localparam logic [SPEED_W:0] BRAKE_W = (SPEED_W + 1)'(BRAKE);
    localparam logic [SPEED_W:0] DRAG_W  = (SPEED_W + 1)'(DRAG);

    race_state_t        state;
    logic [SPEED_W-1:0] speed;
    logic [CNT_W-1:0]   crash_cnt;
    logic               finish_hit;

    // Saturating speed step: up adds amt clamped at MAX_SPEED,
    // otherwise subtracts amt clamped at zero.
    function automatic logic [SPEED_W-1:0] speed_step(
        input logic [SPEED_W-1:0] spd,
        input logic               up,
        input logic [SPEED_W:0]   amt
    );
        logic [SPEED_W:0] wide;
        wide = {1'b0, spd};
        if (up) begin
            wide = wide + amt;
            if (wide > MAX_W) begin
                wide = MAX_W;
            end
        end else begin
            if (amt >= wide) begin
                wide = '0;
            end else begin
                wide = wide - amt;
            end
        end
        return wide[SPEED_W-1:0];
    endfunction

    // Both operands are two's-complement distances.
    assign finish_hit = $signed(distance_drove) >= $signed(track_length);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            speed        <= '0;
            crash_cnt    <= '0;
            crash_active <= 1'b0;
            race_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    speed     <= '0;
                    crash_cnt <= '0;
                    if (startOfFrame && start_race) begin
                        state <= RACE;
                    end
                end

                RACE: begin
                    // Finish outranks a same-cycle collision and pedal step;
                    // speed is carried into FINISH unchanged.
                    if (finish_hit) begin
                        state     <= FINISH;
                        race_done <= 1'b1;
                    end else if (collision) begin
                        state        <= CRASH;
                        speed        <= '0;
                        crash_cnt    <= CNT_LOAD;
                        crash_active <= 1'b1;
                    end else if (startOfFrame) begin
                        if (brake) begin
                            speed <= speed_step(speed, 1'b0, BRAKE_W);
                        end else if (gas) begin
                            speed <= speed_step(speed, 1'b1, ACCEL_W);
                        end else begin
                            speed <= speed_step(speed, 1'b0, DRAG_W);
                        end
                    end
                end

                CRASH: begin
                    speed <= '0;
                    if (finish_hit) begin
                        state        <= FINISH;
                        crash_cnt    <= '0;
                        crash_active <= 1'b0;
                        race_done    <= 1'b1;
                    end else if (startOfFrame) begin
                        // <= 1 rather than == 1 so a zero load cannot stick here.
                        if (crash_cnt <= CNT_ONE) begin
                            state        <= RACE;
                            crash_cnt    <= '0;
                            crash_active <= 1'b0;
                        end else begin
                            crash_cnt <= crash_cnt - CNT_ONE;
                        end
                    end
                end

                FINISH: begin
                    // Coast down under braking; only reset leaves FINISH.
                    if (startOfFrame) begin
                        speed <= speed_step(speed, 1'b0, BRAKE_W);
                    end
                end

                default: begin
                    state        <= IDLE;
                    speed        <= '0;
                    crash_cnt    <= '0;
                    crash_active <= 1'b0;
                    race_done    <= 1'b0;
                end
            endcase
        end
    end

    assign player_speed = speed;
    assign race_state   = state;

endmodule
